// File: rtl/uart_pc_frame_rx.sv
// UART 8N1 receive front-end: deserialises bytes and assembles 15 of them into
// the 120-bit host command word, discarding malformed bytes and stalled frames.
module uart_pc_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned IDLE_TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rxd,
    output logic [119:0] pc_data,
    output logic         pc_valid,
    output logic         frame_err,
    output logic         drop,
    output logic         busy
);

    localparam int unsigned HALF_BIT    = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_MAX     = IDLE_TIMEOUT * CLKS_PER_BIT;
    localparam int unsigned GAP_W       = $clog2(GAP_MAX + 1);
    localparam int unsigned FRAME_BYTES = 15;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rxs;
    logic               armed;
    logic [CNT_W-1:0]   bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic [111:0]       asm_q;
    logic [3:0]         byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // Bit FSM, frame assembly and idle timeout share one register block.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            armed     <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            asm_q     <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            pc_data   <= '0;
            pc_valid  <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rxs       <= rx_meta;
            pc_valid  <= 1'b0;
            frame_err <= 1'b0;
            drop      <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxs) begin
                        armed <= 1'b1;
                    end
                    // A start edge takes priority over a simultaneous timeout.
                    if (!rxs && armed) begin
                        state   <= START;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (byte_cnt != 4'd0) begin
                        if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
                            byte_cnt <= '0;
                            drop     <= 1'b1;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                START: begin
                    if (bit_cnt == CNT_W'(HALF_BIT - 1)) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        bit_cnt <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        if (rxs) begin
                            asm_q <= {asm_q[103:0], shreg};
                            if (byte_cnt == 4'(FRAME_BYTES - 1)) begin
                                pc_data  <= {asm_q, shreg};
                                pc_valid <= 1'b1;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end else begin
                            // Bad stop bit loses the whole partial frame; wait for line high.
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                            armed     <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (byte_cnt != 4'd0);

endmodule

// File: tb/tb_uart_pc_frame_rx.sv
// Directed bench for uart_pc_frame_rx: scoreboarded frames plus pulse, busy and
// reset checks.
module tb_uart_pc_frame_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned ITO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rxd;
    logic [119:0] pc_data;
    logic         pc_valid;
    logic         frame_err;
    logic         drop;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int drop_cnt = 0;
    logic [119:0] exp_q[$];

    uart_pc_frame_rx #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(ITO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .pc_data   (pc_data),
        .pc_valid  (pc_valid),
        .frame_err (frame_err),
        .drop      (drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pc_valid pops the oldest expected frame.
    always @(negedge clk) begin
        if (pc_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) chk("unexpected_valid", 120'(pc_valid), 120'(0));
            else chk("frame_data", pc_data, exp_q.pop_front());
        end
        if (frame_err) ferr_cnt++;
        if (drop) drop_cnt++;
        if (pc_valid || frame_err || drop)
            chk("pulse_exclusive", 120'(32'(pc_valid) + 32'(frame_err) + 32'(drop)), 120'(1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_bytes(input logic [119:0] f, input int first, input int last);
        logic [119:0] v;
        v = f;
        for (int k = first; k <= last; k++) begin
            if (k == 14) exp_q.push_back(v);
            send_byte(v[119 - 8*k -: 8], 1'b1);
        end
    endtask

    logic [119:0] fx, fy;
    int v0, e0, d0, n;
    bit got;

    initial begin
        rxd = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc_data", pc_data, 120'(0));
        chk("rst_busy", 120'(busy), 120'(0));
        chk("rst_valid", 120'(pc_valid), 120'(0));
        chk("rst_ferr", 120'(frame_err), 120'(0));
        chk("rst_drop", 120'(drop), 120'(0));
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Full frame 0x01..0x0F
        v0 = valid_cnt;
        fx = 120'h0102030405060708090A0B0C0D0E0F;
        send_bytes(fx, 0, 14);
        repeat (3) @(negedge clk);
        chk("full_valid_count", 120'(valid_cnt - v0), 120'(1));
        chk("full_top_byte", 120'(pc_data[119:112]), 120'h01);
        chk("full_busy_after", 120'(busy), 120'(0));

        // Glitch shorter than half a bit
        v0 = valid_cnt; e0 = ferr_cnt; d0 = drop_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_valid", 120'(valid_cnt - v0), 120'(0));
        chk("glitch_no_ferr", 120'(ferr_cnt - e0), 120'(0));
        chk("glitch_no_drop", 120'(drop_cnt - d0), 120'(0));
        chk("glitch_busy", 120'(busy), 120'(0));
        chk("glitch_pc_data", pc_data, fx);

        // Bad stop bit on byte 5, then a clean frame
        v0 = valid_cnt; e0 = ferr_cnt;
        for (int k = 0; k < 4; k++) send_byte(8'(8'h50 + k), 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("badstop_ferr_once", 120'(ferr_cnt - e0), 120'(1));
        chk("badstop_no_valid", 120'(valid_cnt - v0), 120'(0));
        chk("badstop_busy", 120'(busy), 120'(0));
        send_bytes(120'hA0A1A2A3A4A5A6A7A8A9AAABACADAE, 0, 14);
        repeat (3) @(negedge clk);
        chk("badstop_recover", pc_data, 120'hA0A1A2A3A4A5A6A7A8A9AAABACADAE);

        // Timeout after 7 bytes
        d0 = drop_cnt; got = 1'b0; n = 0;
        for (int k = 0; k < 7; k++) send_byte(8'(8'h70 + k), 1'b1);
        chk("timeout_busy_before", 120'(busy), 120'(1));
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (drop && !got) begin
                got = 1'b1;
                n = i + 1;
            end
        end
        chk("timeout_drop_once", 120'(drop_cnt - d0), 120'(1));
        chk("timeout_drop_time", 120'(n >= 50 && n <= 66), 120'(1));
        chk("timeout_busy_after", 120'(busy), 120'(0));
        fx = {$urandom, $urandom, $urandom, $urandom};
        send_bytes(fx, 0, 14);
        repeat (3) @(negedge clk);
        chk("timeout_recover", pc_data, fx);

        // Reset asserted during byte 10
        v0 = valid_cnt;
        fy = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 9; k++) send_byte(fy[119 - 8*k -: 8], 1'b1);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_pc_data", pc_data, 120'(0));
        chk("midrst_busy", 120'(busy), 120'(0));
        chk("midrst_pulses", 120'({pc_valid, frame_err, drop}), 120'(0));
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_valid", 120'(valid_cnt - v0), 120'(0));
        send_bytes(fy, 0, 14);
        repeat (3) @(negedge clk);
        chk("midrst_recover", pc_data, fy);

        // Two consecutive frames: X holds until Y completes
        v0 = valid_cnt;
        fx = {$urandom, $urandom, $urandom, $urandom};
        fy = {$urandom, $urandom, $urandom, $urandom};
        send_bytes(fx, 0, 14);
        send_bytes(fy, 0, 13);
        chk("hold_x", pc_data, fx);
        send_bytes(fy, 14, 14);
        repeat (3) @(negedge clk);
        chk("two_valid_count", 120'(valid_cnt - v0), 120'(2));
        chk("two_final", pc_data, fy);
        chk("queue_empty", 120'(exp_q.size()), 120'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_pc_frame_rx.md
# uart_pc_frame_rx

Receive front-end for the UART command path. Deserialises 8N1 bytes from the host's serial line, assembles 15 consecutive bytes into the 120-bit host command word (`pc_data`), and hands it downstream with a one-cycle valid pulse. Its output feeds the command decoder directly; that decoder slices `pc_data` into its action, address and data fields. Malformed bytes and stalled partial frames are discarded so the decoder only ever sees complete frames.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `IDLE_TIMEOUT`, default 32: bit periods of line idle after which a partial frame is dropped.
- `clk`  in  1  system clock. This is the block's only clock.
- `rst_n`  in  1  synchronous, active-high reset. The block resets on the `clk` edge where `rst_n` = 1.
- `rxd`  in  1  asynchronous serial input; idles high.
- `pc_data`  out  120  last complete frame. The first received byte is in [119:112]; the 15th byte is in [7:0].
- `pc_valid`  out  1  one-cycle pulse when `pc_data` has just been updated.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is seen.
- `drop`  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- `busy`  out  1  high while a byte is in progress or the frame is partially filled.

## Operation
- **Input synchroniser.** `rxd` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rxs`.
- **Bit FSM states:** IDLE, START, DATA, STOP. A bit-period counter and a 3-bit bit index drive the FSM.
  - **IDLE → START:** when `rxs` = 0. The counter is cleared.
  - **START:** wait H = CLKS_PER_BIT/2 (floor), then sample `rxs`.
    - Sample = 1: false start; return to IDLE. There is no error pulse and the frame state is unchanged.
    - Sample = 0: go to DATA.
  - **DATA:** sample every CLKS_PER_BIT cycles, 8 samples in total. Bits arrive LSB first and shift into the byte register.
  - **STOP:** sample `rxs` once, CLKS_PER_BIT cycles after data bit 7.
    - Sample = 1: commit the byte.
    - Sample = 0: pulse `frame_err`, discard the byte, and clear the byte count (the whole partial frame is lost). Go to IDLE, which re-arms only after `rxs` has been seen high for one cycle.
- **Frame assembly.**
  - On each byte commit: `asm` <= {asm[111:0], byte} and `byte_cnt` increments. `byte_cnt` is 4-bit and counts 0..14.
  - On the commit where `byte_cnt` = 14:
    - `pc_data` <= {asm[111:0], byte}
    - `pc_valid` pulses
    - `byte_cnt` <= 0
  - `pc_data` holds its value until the next complete frame.
- **Timeout.** A gap counter runs only while the FSM is in IDLE and `byte_cnt` ≠ 0.
  - It clears on any START entry.
  - On reaching IDLE_TIMEOUT × CLKS_PER_BIT cycles: `byte_cnt` <= 0, `drop` pulses once, and the counter clears and stops.
- **Busy.** `busy` = (state ≠ IDLE) | (`byte_cnt` ≠ 0).
- **Pulse exclusivity.** `pc_valid`, `frame_err` and `drop` are mutually exclusive in any cycle by construction.

## Timing
- **Reset values:**
  - `pc_data` = 0; `pc_valid`, `frame_err`, `drop`, `busy` = 0.
  - State IDLE; all counters and `asm` = 0; synchroniser = 1.
- **Reset mid-operation:** reset asserted at any point aborts the byte and the frame. No pulse is issued.
- **Sample points.** Let T be the cycle in which IDLE first sees `rxs` = 0.
  - Start bit sampled at T+H.
  - Data bit i sampled at T+H+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at T+H+9·CLKS_PER_BIT.
- **Commit timing.** The byte commit, `pc_valid` and `frame_err` are registered and visible in the cycle after the stop sample. The FSM is in IDLE in that same cycle.
- **Back-to-back bytes.** A start edge arriving immediately after the stop-bit midpoint is accepted with no lost byte.
- **End-to-end latency.** From the host's start bit of byte 15 to `pc_valid` is about 9.5 bit periods plus 3 cycles: 2 synchroniser cycles plus 1 register cycle.
- **Handshake.** There is no backpressure; the consumer must take `pc_data` while `pc_valid` is high or any later cycle before the next frame completes.
- **Simultaneous events.** A timeout and a start detection in the same cycle: start wins, and there is no drop.

## Test plan
Bench uses CLKS_PER_BIT = 16, IDLE_TIMEOUT = 4.
- **Full frame.** Send bytes 0x01..0x0F back to back → exactly one `pc_valid` pulse; `pc_data` = 0x0102030405060708090A0B0C0D0E0F, with [119:112] = 0x01. `busy` = 0 afterwards.
- **Glitch rejection.** Drive `rxd` low for 5 cycles (< H = 8), then high → no byte committed, no pulses; `busy` returns to 0 and `byte_cnt` is unchanged.
- **Bad stop bit.** Send byte 5 of a frame with stop = 0 → `frame_err` pulses once, no `pc_valid`. The next 15 good bytes 0xA0..0xAE yield `pc_data` = 0xA0A1...AE.
- **Timeout.** Send 7 bytes, then hold `rxd` high for more than 64 cycles → `drop` pulses once at 64 idle cycles and `busy` = 0. A following 15-byte frame is assembled correctly.
- **Reset mid-frame.** Assert `rst_n` during byte 10 → all outputs 0 next cycle. A subsequent full frame is correct with no stale bytes.
- **Two consecutive frames.** Send frames X then Y → `pc_data` holds X until Y's `pc_valid` cycle. Exactly two `pc_valid` pulses.
